// File: rtl/wb_write_queue.sv
// In-order write-back queue feeding the register file write port, with
// youngest-match forwarding of pending writes on two lookup ports.
module wb_write_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_reg,
  input  logic [DW-1:0]              in_data,
  input  logic                       rf_hold,
  output logic [AW-1:0]              rf_write_reg,
  output logic [DW-1:0]              rf_write_data,
  output logic                       rf_regWrite,
  input  logic [AW-1:0]              lk_reg1,
  input  logic [AW-1:0]              lk_reg2,
  output logic                       lk_hit1,
  output logic                       lk_hit2,
  output logic [DW-1:0]              lk_data1,
  output logic [DW-1:0]              lk_data2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] rg;
    logic [DW-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   cnt;
  logic            push;
  logic            pop;

  assign count    = cnt;
  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign in_ready = !full;

  // Register-0 requests are handshaken but never stored.
  assign push = in_valid && !full && (in_reg != '0);
  assign pop  = !empty && !rf_hold;

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  // Entry storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{rg: in_reg, data: in_data};
  end

  // Register file write port: head entry, shown under hold, zero when empty.
  always_comb begin
    rf_regWrite   = 1'b0;
    rf_write_reg  = '0;
    rf_write_data = '0;
    if (!empty) begin
      rf_write_reg  = mem[head].rg;
      rf_write_data = mem[head].data;
      rf_regWrite   = !rf_hold;
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    logic [PW-1:0] idx;
    lk_hit1  = 1'b0;
    lk_hit2  = 1'b0;
    lk_data1 = '0;
    lk_data2 = '0;
    idx      = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      idx = head + PW'(k);
      if (CW'(k) < cnt) begin
        if ((lk_reg1 != '0) && (mem[idx].rg == lk_reg1)) begin
          lk_hit1  = 1'b1;
          lk_data1 = mem[idx].data;
        end
        if ((lk_reg2 != '0) && (mem[idx].rg == lk_reg2)) begin
          lk_hit2  = 1'b1;
          lk_data2 = mem[idx].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: table of per-cycle vectors plus a
// hand-written reset-during-drain sequence.
module tb_wb_write_queue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        rf_hold;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        rf_regWrite;
  logic [4:0]  lk_reg1;
  logic [4:0]  lk_reg2;
  logic        lk_hit1;
  logic        lk_hit2;
  logic [31:0] lk_data1;
  logic [31:0] lk_data2;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int n_cmp  = 0;
  int n_fail = 0;

  wb_write_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .rf_hold(rf_hold), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .rf_regWrite(rf_regWrite),
    .lk_reg1(lk_reg1), .lk_reg2(lk_reg2), .lk_hit1(lk_hit1), .lk_hit2(lk_hit2),
    .lk_data1(lk_data1), .lk_data2(lk_data2),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rg;
    logic [31:0] d;
    logic        hold;
    logic [4:0]  l1;
    logic [4:0]  l2;
    logic [2:0]  cnt;
    logic        rdy;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        h1;
    logic [31:0] d1;
    logic        h2;
    logic [31:0] d2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [4:0] rg, logic [31:0] d, logic hold,
                              logic [4:0] l1, logic [4:0] l2, logic [2:0] cnt,
                              logic rdy, logic we, logic [4:0] wr, logic [31:0] wd,
                              logic h1, logic [31:0] d1, logic h2, logic [31:0] d2);
    vec_t r;
    r.v = v; r.rg = rg; r.d = d; r.hold = hold; r.l1 = l1; r.l2 = l2;
    r.cnt = cnt; r.rdy = rdy; r.we = we; r.wr = wr; r.wd = wd;
    r.h1 = h1; r.d1 = d1; r.h2 = h2; r.d2 = d2;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " regWrite"}, 32'(rf_regWrite), 32'd0);
    chk({tag, " count"},    32'(count),       32'd0);
    chk({tag, " empty"},    32'(empty),       32'd1);
    chk({tag, " full"},     32'(full),        32'd0);
    chk({tag, " in_ready"}, 32'(in_ready),    32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_reg = '0; in_data = '0;
    rf_hold = 1'b0; lk_reg1 = '0; lk_reg2 = '0;

    // v  rg  data          hold l1  l2  cnt rdy we wr  wdata         h1 d1            h2 d2
    vecs.push_back(mk(0, 0,  32'h0,        0, 0,  0,  0, 1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 5,  32'h00003000, 0, 0,  0,  0, 1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 5,  0,  1, 1, 1, 5,  32'h00003000, 1, 32'h00003000, 0, 32'h0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 5,  0,  0, 1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 0,  32'hDEADBEEF, 0, 0,  0,  0, 1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0,  0,  0, 1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 31, 32'hFFFFFFFF, 1, 0,  0,  0, 1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 31, 32'h12345678, 1, 31, 2,  1, 1, 0, 31, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0, 32'h0));
    vecs.push_back(mk(0, 0,  32'h0,        1, 31, 2,  2, 1, 0, 31, 32'hFFFFFFFF, 1, 32'h12345678, 0, 32'h0));
    vecs.push_back(mk(1, 2,  32'h000000A2, 0, 31, 2,  2, 1, 1, 31, 32'hFFFFFFFF, 1, 32'h12345678, 0, 32'h0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 31, 2,  2, 1, 1, 31, 32'h12345678, 1, 32'h12345678, 1, 32'h000000A2));
    vecs.push_back(mk(0, 0,  32'h0,        0, 31, 2,  1, 1, 1, 2,  32'h000000A2, 0, 32'h0,        1, 32'h000000A2));
    vecs.push_back(mk(0, 0,  32'h0,        0, 31, 2,  0, 1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 1,  32'h00000011, 1, 0,  0,  0, 1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 2,  32'h00000022, 1, 1,  0,  1, 1, 0, 1,  32'h00000011, 1, 32'h00000011, 0, 32'h0));
    vecs.push_back(mk(1, 3,  32'h00000033, 1, 0,  0,  2, 1, 0, 1,  32'h00000011, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 4,  32'h00000044, 1, 0,  0,  3, 1, 0, 1,  32'h00000011, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 8,  32'h00000088, 1, 4,  8,  4, 0, 0, 1,  32'h00000011, 1, 32'h00000044, 0, 32'h0));
    vecs.push_back(mk(1, 6,  32'h00000066, 0, 0,  0,  4, 0, 1, 1,  32'h00000011, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 6,  32'h00000066, 0, 0,  0,  3, 1, 1, 2,  32'h00000022, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 7,  32'h00000077, 0, 6,  0,  3, 1, 1, 3,  32'h00000033, 1, 32'h00000066, 0, 32'h0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0,  0,  3, 1, 1, 4,  32'h00000044, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 7,  6,  2, 1, 1, 6,  32'h00000066, 1, 32'h00000077, 1, 32'h00000066));
    vecs.push_back(mk(0, 0,  32'h0,        0, 7,  6,  1, 1, 1, 7,  32'h00000077, 1, 32'h00000077, 0, 32'h0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 7,  6,  0, 1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0));

    // Reset state while rst_n is held low.
    #2;
    chk_idle("reset");
    chk("reset wreg",  32'(rf_write_reg), 32'd0);
    chk("reset wdata", rf_write_data,     32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("v%0d", i);
      in_valid = vecs[i].v; in_reg = vecs[i].rg; in_data = vecs[i].d;
      rf_hold = vecs[i].hold; lk_reg1 = vecs[i].l1; lk_reg2 = vecs[i].l2;
      #1;
      chk({t, " count"},    32'(count),         32'(vecs[i].cnt));
      chk({t, " in_ready"}, 32'(in_ready),      32'(vecs[i].rdy));
      chk({t, " full"},     32'(full),          32'(vecs[i].cnt == 3'd4));
      chk({t, " empty"},    32'(empty),         32'(vecs[i].cnt == 3'd0));
      chk({t, " regWrite"}, 32'(rf_regWrite),   32'(vecs[i].we));
      chk({t, " wreg"},     32'(rf_write_reg),  32'(vecs[i].wr));
      chk({t, " wdata"},    rf_write_data,      vecs[i].wd);
      chk({t, " hit1"},     32'(lk_hit1),       32'(vecs[i].h1));
      chk({t, " data1"},    lk_data1,           vecs[i].d1);
      chk({t, " hit2"},     32'(lk_hit2),       32'(vecs[i].h2));
      chk({t, " data2"},    lk_data2,           vecs[i].d2);
      @(posedge clk);
      #1;
    end

    // Reset asserted mid-drain: outputs must clear without a clock edge.
    lk_reg1 = 5'd9; lk_reg2 = 5'd0; rf_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_reg = 5'(9 + k); in_data = 32'h900 + 32'(k);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; rf_hold = 1'b0;
    #1;
    chk("drain count",    32'(count),       32'd3);
    chk("drain regWrite", 32'(rf_regWrite), 32'd1);
    chk("drain wreg",     32'(rf_write_reg), 32'd9);
    chk("drain hit1",     32'(lk_hit1),     32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle("midrst");
    chk("midrst wreg",  32'(rf_write_reg), 32'd0);
    chk("midrst wdata", rf_write_data,     32'd0);
    chk("midrst hit1",  32'(lk_hit1),      32'd0);
    chk("midrst data1", lk_data1,          32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_idle($sformatf("postrst%0d", k));
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
